// File: rtl/booth_mult_sched.sv
// booth_mult_sched: round-robin scheduler sharing one sequential radix-2 Booth multiplier.
// Optional saturating completed-operation counter, built only when BOOTH_SCHED_STATS_EN is defined.
module booth_mult_sched #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_multiplier,
    input  logic [NREQ*WIDTH-1:0] req_multiplicand,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*WIDTH-1:0]    rsp_product,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy,
    output logic [15:0]           stat_ops
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       st_q, st_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm_q, qm_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             found;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   a_sum;

    assign m_ext = {m_q[WIDTH-1], m_q};

    // Rotating priority search starting at ptr; first valid requester wins.
    always_comb begin
        found     = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        req_ready = '0;
        if (st_q == S_IDLE) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cand = IDW'((32'(ptr_q) + i) % NREQ);
                if (!found && req_valid[cand]) begin
                    found   = 1'b1;
                    gnt_idx = cand;
                end
            end
            if (found) req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        st_d  = st_q;
        ptr_d = ptr_q;
        id_d  = id_q;
        m_d   = m_q;
        a_d   = a_q;
        q_d   = q_q;
        qm_d  = qm_q;
        cnt_d = cnt_q;
        case ({q_q[0], qm_q})
            2'b10:   a_sum = a_q - m_ext;
            2'b01:   a_sum = a_q + m_ext;
            default: a_sum = a_q;
        endcase
        case (st_q)
            S_IDLE: begin
                if (found) begin
                    m_d   = req_multiplicand[32'(gnt_idx) * WIDTH +: WIDTH];
                    q_d   = req_multiplier[32'(gnt_idx) * WIDTH +: WIDTH];
                    a_d   = '0;
                    qm_d  = 1'b0;
                    cnt_d = CW'(WIDTH);
                    id_d  = gnt_idx;
                    ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    st_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Arithmetic right shift of {A, Q, q_minus} after the add/subtract.
                {a_d, q_d, qm_d} = {a_sum[WIDTH], a_sum, q_q};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) st_d = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) st_d = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= S_IDLE;
            ptr_q <= '0;
            id_q  <= '0;
            m_q   <= '0;
            a_q   <= '0;
            q_q   <= '0;
            qm_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            ptr_q <= ptr_d;
            id_q  <= id_d;
            m_q   <= m_d;
            a_q   <= a_d;
            q_q   <= q_d;
            qm_q  <= qm_d;
            cnt_q <= cnt_d;
        end
    end

    assign rsp_valid   = (st_q == S_DONE);
    assign busy        = (st_q != S_IDLE);
    assign rsp_id      = id_q;
    assign rsp_product = {a_q[WIDTH-1:0], q_q};

`ifdef BOOTH_SCHED_STATS_EN
    logic [15:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (rsp_valid && rsp_ready && (stat_q != '1)) stat_d = stat_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stat_q <= '0;
        else        stat_q <= stat_d;
    end

    assign stat_ops = stat_q;
`else
    assign stat_ops = '0;
`endif

endmodule

// File: doc/booth_mult_sched.md
# booth_mult_sched

Round-robin scheduler that shares one sequential radix-2 Booth multiply datapath between NREQ requesters. Each requester offers a signed operand pair over a valid/ready handshake. The block grants one requester at a time, runs one Booth recode/add/arithmetic-shift step per clock for WIDTH clocks, and returns the signed 2·WIDTH-bit product tagged with the requester index. It sits between the operand producers and the consumers of products, which share a single response channel.

## Interface
- WIDTH, 4, signed operand width (≥2)
- NREQ, 2, number of requesters (2..8); IDW = max(1, clog2(NREQ))
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  requester i offers an operand pair
- req_ready  out  NREQ  one-hot grant/accept strobe
- req_multiplier  in  NREQ·WIDTH  signed; requester i at [i·WIDTH +: WIDTH]
- req_multiplicand  in  NREQ·WIDTH  signed; same packing
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer accepts product
- rsp_product  out  2·WIDTH  signed product
- rsp_id  out  IDW  index of the requester that owns the product
- busy  out  1  high in RUN or DONE
- stat_ops  out  16  completed-operation count (see Configuration)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE arbitration: search req_valid starting at ptr, then ptr+1 … mod NREQ. The first valid index g gets req_ready[g]=1, combinationally, in the same cycle. All other ready bits are 0. req_ready is 0 in RUN and DONE.
- Accept = req_valid[g] & req_ready[g] at a clock edge. On accept:
  - Latch operands: M ← multiplicand, Q ← multiplier.
  - Clear the accumulator A (WIDTH+1 bits) and q_minus. Load step count = WIDTH.
  - Set rsp_id ← g and ptr ← (g+1) mod NREQ. Enter RUN.
- ptr resets to 0 and changes only on accept.
- RUN step, one per edge, by {Q[0], q_minus}:
  - 10: A ← A − sext(M)
  - 01: A ← A + sext(M)
  - 00 or 11: no change
  - Then arithmetic right shift of {A, Q, q_minus} by one. Decrement the count.
  - After the WIDTH-th step, enter DONE.
- A is WIDTH+1 bits so that every operand pair gives an exact product, including −2^(W−1)·−2^(W−1).
- rsp_product = low 2·WIDTH bits of {A, Q}. Required result: exact signed multiplier × multiplicand.
- DONE: rsp_valid=1. rsp_product and rsp_id are held stable until rsp_valid & rsp_ready at an edge, then → IDLE.
- Operand changes, and req_valid drops from non-granted requesters, have no effect outside the accept edge.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_product=0, rsp_id=0, busy=0, stat_ops=0.
- Accept at edge E0. Steps at E1..E_WIDTH. rsp_valid rises after E_WIDTH.
- Response taken at edge Ed (Ed ≥ E_WIDTH+1). IDLE follows Ed. The next accept can happen no earlier than Ed+1.
- Minimum spacing between accepts is WIDTH+2 edges.
- If rsp_ready is held high, rsp_valid is high for exactly one cycle.
- Reset asserted in RUN or DONE aborts the operation with no response. All state, including ptr, returns to reset values immediately.
- No combinational path from rsp_ready to any output.

## Configuration
- BOOTH_SCHED_STATS_EN defined:
  - stat_ops increments by 1 on each response handshake and saturates at 16'hFFFF.
  - stat_ops is cleared only by reset.
- Undefined: stat_ops is tied to 0 and no counter logic is built. Port list is unchanged.

## Test plan
- Reset: rst_n low mid-cycle, with no clock → all outputs at reset values immediately. IDLE with req_valid=0 → req_ready=0.
- Single op, WIDTH=4, requester 0, multiplier=3, multiplicand=−2, rsp_ready=1 → rsp_valid 4 edges after accept, rsp_product=8'hFA, rsp_id=0, one-cycle pulse.
- Corner products, each checked for exactness and for 4-edge latency:
  - −8 × −8 → 8'h40
  - −8 × 7 → 8'hC8
  - 7 × 7 → 8'h31
  - 0 × −5 → 8'h00
- Fairness: req_valid=2'b11 held, rsp_ready=1 → grant order 0,1,0,1 with matching rsp_id. Accepts spaced exactly 6 edges apart.
- Backpressure: rsp_ready=0 for 3 cycles after rsp_valid → product and id held, no new accept, busy=1. rsp_ready=1 → handshake, then IDLE.
- Reset mid-RUN, after 2 steps → no rsp_valid, ptr=0. The next op with both valid grants requester 0. With the macro defined, stat_ops=0 after reset, then 1 after the next completed op.
